mem_arbiter: RTL and testbench

- Shares the single burst physical-memory port between the instruction-side cache (line reads only) and the data-side cache (line reads and writebacks).
- Sits between the two L1 caches and pmem.
- Serialises each 256-bit line into 64-bit beats and reassembles it.
- Arbitrates with alternating priority so neither side starves; data-side mem_read/mem_write traffic from the control word reaches pmem only through this block.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_line_serdes.sv | 72 +++++++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_types: shared types and constants for the memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which cache side owns (or last owned) the pmem port
//   LINE_BITS / BEAT_BITS / BEATS : line geometry
//   line_align() : clears the byte-in-line offset of an address
// -----------------------------------------------------------------------------
package arb_types;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    RESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // A line is 32 bytes, so the low 5 address bits select a byte within it.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:5], 5'b00000};
  endfunction

endpackage

// File: rtl/mem_arbiter_line_serdes.sv
// -----------------------------------------------------------------------------
// line_serdes: one 256-bit line buffer plus a 2-bit beat counter, shared by all
// bursts (only one is ever in flight).
//   clk, rst    : clock, synchronous active-low reset
//   load_i      : load line_i and restart at beat 0
//   line_i      : line to load (writeback data, or zero for reads)
//   step_i      : a beat completed this cycle; advance the counter
//   capture_i   : together with step_i, store beat_i into the current slot
//   beat_i      : incoming read beat
//   beat_o      : current beat of the buffered line (outgoing write data)
//   merged_o    : buffered line with beat_i placed in the current slot
//   last_o      : step_i on the final beat
// -----------------------------------------------------------------------------
module line_serdes
  import arb_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LINE_BITS-1:0] line_i,
  input  logic                 step_i,
  input  logic                 capture_i,
  input  logic [BEAT_BITS-1:0] beat_i,
  output logic [BEAT_BITS-1:0] beat_o,
  output logic [LINE_BITS-1:0] merged_o,
  output logic                 last_o
);

  logic [LINE_BITS-1:0] line_q, line_d;
  logic [1:0]           cnt_q, cnt_d;

  // Beat select and read-beat merge; merged_o lets the top capture a finished
  // line in the same edge as its final beat.
  always_comb begin
    beat_o   = line_q[cnt_q * BEAT_BITS +: BEAT_BITS];
    merged_o = line_q;
    merged_o[cnt_q * BEAT_BITS +: BEAT_BITS] = beat_i;
    last_o   = step_i && (cnt_q == 2'd3);
  end

  // Next line contents and beat position.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      line_d = line_i;
      cnt_d  = 2'd0;
    end else if (step_i) begin
      if (capture_i) begin
        line_d = merged_o;
      end else begin
        line_d = line_q;
      end
      cnt_d = cnt_q + 2'd1;
    end else begin
      line_d = line_q;
      cnt_d  = cnt_q;
    end
  end

  // Line buffer and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter: shares one burst pmem port between the I-cache (line reads) and
// the D-cache (line reads and writebacks). Lines are moved as four 64-bit beats.
//   clk, rst                      : clock, synchronous active-low reset
//   i_read, i_address             : I-side read request / byte address
//   i_rdata, i_resp               : I-side assembled line / 1-cycle completion
//   d_read, d_write, d_address    : D-side request (both high = write) / address
//   d_wdata                       : D-side writeback line, sampled at grant
//   d_rdata, d_resp               : D-side assembled line / 1-cycle completion
//   pmem_read, pmem_write         : burst request strobes
//   pmem_address                  : line-aligned burst address
//   pmem_wdata / pmem_rdata       : outgoing / incoming beat
//   pmem_resp                     : one beat accepted/returned this cycle
// -----------------------------------------------------------------------------
module mem_arbiter
  import arb_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [31:0]          i_address,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_address,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [BEAT_BITS-1:0] pmem_wdata,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  arb_state_t           state_q, state_d;
  grant_t               last_grant_q, last_grant_d;
  logic                 mask_q, mask_d;
  logic                 i_resp_q, i_resp_d;
  logic                 d_resp_q, d_resp_d;
  logic                 pmem_read_q, pmem_read_d;
  logic                 pmem_write_q, pmem_write_d;
  logic [31:0]          pmem_address_q, pmem_address_d;
  logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;

  logic                 i_elig_s, d_elig_s;
  logic                 grant_i_s, grant_d_s, grant_s;
  logic                 burst_s, rd_burst_s, step_s, last_s;
  logic [LINE_BITS-1:0] load_line_s, merged_s;
  logic [BEAT_BITS-1:0] beat_s;

  line_serdes u_serdes (
    .clk       (clk),
    .rst       (rst),
    .load_i    (grant_s),
    .line_i    (load_line_s),
    .step_i    (step_s),
    .capture_i (rd_burst_s),
    .beat_i    (pmem_rdata),
    .beat_o    (beat_s),
    .merged_o  (merged_s),
    .last_o    (last_s)
  );

  // Arbitration. mask_q marks the first IDLE cycle after RESP; the side just
  // served (always last_grant_q) may still be holding its request then.
  always_comb begin
    i_elig_s   = i_read && !(mask_q && (last_grant_q == GRANT_I));
    d_elig_s   = (d_read || d_write) && !(mask_q && (last_grant_q == GRANT_D));
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    if (state_q == IDLE) begin
      grant_i_s = i_elig_s && (!d_elig_s || (last_grant_q == GRANT_D));
      grant_d_s = d_elig_s && !grant_i_s;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
    grant_s     = grant_i_s || grant_d_s;
    load_line_s = (grant_d_s && d_write) ? d_wdata : '0;
    burst_s     = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
    rd_burst_s  = (state_q == I_RD) || (state_q == D_RD);
    step_s      = burst_s && pmem_resp;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      mask_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mask_q       <= mask_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mask_d       = (state_q == RESP);
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          state_d      = I_RD;
          last_grant_d = GRANT_I;
        end else if (grant_d_s) begin
          // d_read together with d_write is treated as a writeback.
          state_d      = d_write ? D_WR : D_RD;
          last_grant_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (last_s) begin
          state_d = RESP;
        end else begin
          state_d = state_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    pmem_read_d    = (state_d == I_RD) || (state_d == D_RD);
    pmem_write_d   = (state_d == D_WR);
    i_resp_d       = (state_q == I_RD) && last_s;
    d_resp_d       = ((state_q == D_RD) || (state_q == D_WR)) && last_s;
    pmem_address_d = pmem_address_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    if (grant_i_s) begin
      pmem_address_d = line_align(i_address);
    end else if (grant_d_s) begin
      pmem_address_d = line_align(d_address);
    end else begin
      pmem_address_d = pmem_address_q;
    end
    if ((state_q == I_RD) && last_s) begin
      i_rdata_d = merged_s;
    end else if ((state_q == D_RD) && last_s) begin
      d_rdata_d = merged_s;
    end else begin
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 32'h0000_0000;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      i_resp_q       <= i_resp_d;
      d_resp_q       <= d_resp_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  // Write data is only presented during a write burst.
  assign pmem_wdata   = pmem_write_q ? beat_s : 64'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata, pmem_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  bit auto_mem = 1'b0;
  bit auto_req = 1'b0;
  int i_drop   = -1;
  int d_drop   = -1;
  int n_iresp  = 0;
  int n_dresp  = 0;

  // Transaction-level model: the current burst, who owns it and what the
  // outputs must show. side: 0 = I, 1 = D. m_mask: side to ignore once, -1 none.
  bit           m_busy  = 1'b0;
  bit           m_resp  = 1'b0;
  bit           m_side  = 1'b0;
  bit           m_wr    = 1'b0;
  bit           m_last  = 1'b1;
  int           m_mask  = -1;
  int           m_beats = 0;
  logic [31:0]  m_addr  = 32'h0;
  logic [255:0] m_wline = '0;
  logic [255:0] m_rline = '0;
  logic [255:0] e_irdata = '0;
  logic [255:0] e_drdata = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit ie, de, side;
    if (!rst) begin
      m_busy = 1'b0; m_resp = 1'b0; m_side = 1'b0; m_wr = 1'b0; m_last = 1'b1;
      m_mask = -1; m_beats = 0; m_addr = 32'h0; m_wline = '0; m_rline = '0;
      e_irdata = '0; e_drdata = '0;
    end else if (m_resp) begin
      m_resp = 1'b0;
      m_mask = m_side ? 1 : 0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        if (!m_wr) m_rline[m_beats*64 +: 64] = pmem_rdata;
        m_beats++;
        if (m_beats == 4) begin
          m_busy = 1'b0;
          m_resp = 1'b1;
          if (!m_wr && !m_side) e_irdata = m_rline;
          if (!m_wr && m_side)  e_drdata = m_rline;
        end
      end
    end else begin
      ie = i_read && (m_mask != 0);
      de = (d_read || d_write) && (m_mask != 1);
      m_mask = -1;
      if (ie || de) begin
        side    = (ie && de) ? !m_last : de;
        m_side  = side;
        m_last  = side;
        m_busy  = 1'b1;
        m_beats = 0;
        m_wr    = side && d_write;
        m_addr  = (side ? d_address : i_address) & 32'hFFFF_FFE0;
        m_wline = d_wdata;
        m_rline = '0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("pmem_read",    pmem_read,    m_busy && !m_wr);
      chk("pmem_write",   pmem_write,   m_busy && m_wr);
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_wdata",   pmem_wdata,   (m_busy && m_wr) ? m_wline[m_beats*64 +: 64] : 64'h0);
      chk("i_resp",       i_resp,       m_resp && !m_side);
      chk("d_resp",       d_resp,       m_resp && m_side);
      chk("i_rdata",      i_rdata,      e_irdata);
      chk("d_rdata",      d_rdata,      e_drdata);
    end
  end

  // Advance to the next falling edge, then apply any automatic stimulus.
  task automatic cyc();
    int r;
    @(negedge clk);
    if (i_resp) n_iresp++;
    if (d_resp) n_dresp++;
    if (auto_mem) begin
      pmem_resp  = (pmem_read || pmem_write) ? ($urandom % 3 != 0) : ($urandom % 8 == 0);
      pmem_rdata = {$urandom, $urandom};
    end
    if (auto_req) begin
      if (i_resp) i_drop = $urandom_range(0, 2);
      if (i_drop == 0) begin
        i_read = 1'b0; i_drop = -1;
      end else if (i_drop > 0) begin
        i_drop--;
      end else if (!i_read) begin
        i_read = ($urandom % 4 == 0);
      end else begin
        i_read = ($urandom % 64 != 0);
      end
      if (d_resp) d_drop = $urandom_range(0, 2);
      if (d_drop == 0) begin
        d_read = 1'b0; d_write = 1'b0; d_drop = -1;
      end else if (d_drop > 0) begin
        d_drop--;
      end else if (!d_read && !d_write) begin
        if ($urandom % 4 == 0) begin
          r = $urandom % 4;
          d_read  = (r == 0) || (r == 1) || (r == 3);
          d_write = (r == 2) || (r == 3);
        end
      end else if ($urandom % 64 == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end
      i_address = $urandom;
      d_address = $urandom;
      d_wdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rst       = ($urandom % 500 != 0);
    end
  endtask

  task automatic beat(input logic [63:0] data);
    pmem_resp = 1'b1; pmem_rdata = data;
    cyc();
    pmem_resp = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    for (int t = 0; t < 300 && quiet < 3; t++) begin
      cyc();
      if (!pmem_read && !pmem_write && !i_resp && !d_resp) quiet++;
      else quiet = 0;
    end
    chk("drain_quiet", quiet >= 3, 1'b1);
  endtask

  int order[$];
  bit seen;

  initial begin
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = 32'h0; d_address = 32'h0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = 64'h0;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("reset_strobes", {i_resp, d_resp, pmem_read, pmem_write}, 4'b0000);
    chk("reset_addr", pmem_address, 32'h0);
    chk("reset_rdata", i_rdata | d_rdata, 256'h0);
    rst = 1'b1;

    // I-only read with a gap after beat 1.
    i_read = 1'b1; i_address = 32'h0000_1234;
    cyc();
    chk("iread_strobe", {pmem_read, pmem_write}, 2'b10);
    chk("iread_addr", pmem_address, 32'h0000_1220);
    beat(64'h1111_1111_1111_1111);
    beat(64'h2222_2222_2222_2222);
    cyc();
    beat(64'h3333_3333_3333_3333);
    chk("iread_before_last", pmem_read, 1'b1);
    beat(64'h4444_4444_4444_4444);
    chk("iread_resp", {i_resp, d_resp}, 2'b10);
    chk("iread_line", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    i_read = 1'b0;
    cyc();
    chk("iread_resp_once", {i_resp, pmem_read}, 2'b00);

    // D writeback from an unaligned address.
    d_write = 1'b1; d_address = 32'h8000_003F;
    d_wdata = {64'd4, 64'd3, 64'd2, 64'd1};
    cyc();
    chk("dwr_strobe", {pmem_read, pmem_write}, 2'b01);
    chk("dwr_addr", pmem_address, 32'h8000_0020);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dwr_beat%0d", k), pmem_wdata, 64'(k + 1));
      beat(64'hDEAD_BEEF_0000_0000);
    end
    chk("dwr_resp", {i_resp, d_resp}, 2'b01);
    chk("dwr_rdata_kept", d_rdata, 256'h0);
    d_write = 1'b0;
    cyc();

    // Reset in the middle of a writeback, then restart from beat 0.
    d_write = 1'b1; d_address = 32'h0000_4000;
    cyc();
    beat(64'h0);
    rst = 1'b0; pmem_resp = 1'b1;
    cyc();
    chk("midrst_outputs", {pmem_write, pmem_read, d_resp, i_resp}, 4'b0000);
    chk("midrst_addr", pmem_address, 32'h0);
    cyc();
    chk("midrst_no_resp", d_resp, 1'b0);
    rst = 1'b1; pmem_resp = 1'b0;
    cyc();
    chk("midrst_restart", {pmem_write, pmem_wdata}, {1'b1, 64'd1});
    for (int k = 0; k < 4; k++) beat(64'h0);
    chk("midrst_done", d_resp, 1'b1);
    d_write = 1'b0;
    drain();

    // Contention straight after reset, both sides held: I, D, I, D.
    rst = 1'b0;
    cyc();
    rst = 1'b1; auto_mem = 1'b1;
    i_read = 1'b1; d_read = 1'b1;
    order.delete();
    for (int t = 0; t < 400 && order.size() < 4; t++) begin
      cyc();
      if (i_resp) order.push_back(0);
      if (d_resp) order.push_back(1);
    end
    i_read = 1'b0; d_read = 1'b0;
    chk("contend_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk($sformatf("contend_order%0d", k), order[k], k % 2);
    drain();

    // Re-request mask: i_read held one cycle past completion.
    i_read = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      cyc();
      seen = i_resp;
    end
    chk("mask_served", seen, 1'b1);
    cyc();
    cyc();
    chk("mask_no_regrant", pmem_read, 1'b0);
    i_read = 1'b0;
    cyc();
    chk("mask_idle", pmem_read, 1'b0);
    drain();

    // d_read and d_write together decode as a writeback.
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0100;
    auto_mem = 1'b0;
    cyc();
    chk("illegal_is_write", {pmem_write, pmem_read}, 2'b10);
    auto_mem = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      cyc();
      seen = d_resp;
    end
    chk("illegal_done", seen, 1'b1);
    d_read = 1'b0; d_write = 1'b0;
    drain();

    // Randomised traffic, gaps, stray pmem_resp and occasional resets.
    n_iresp = 0; n_dresp = 0;
    auto_req = 1'b1;
    for (int t = 0; t < 5000; t++) cyc();
    auto_req = 1'b0;
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    drain();
    chk("random_progress", (n_iresp > 20) && (n_dresp > 20), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
